// File: rtl/lsq_mem_controller_if.sv
// Bundle of LSQ-side request/response and memory-side signals for lsq_mem_controller.
// The controller connects through the slave modport; the LSQ/memory side uses master.
interface lsq_mem_controller_if #(
  parameter int CNT_W = 3
);
  logic             load_req_valid;
  logic             load_req_ready;
  logic [31:0]      load_req_addr;
  logic             load_req_BMS;
  logic [5:0]       load_req_tag;
  logic [5:0]       load_req_ROB_index;
  logic             store_req_valid;
  logic             store_req_ready;
  logic [31:0]      store_req_addr;
  logic [31:0]      store_req_value;
  logic             store_req_BMS;
  logic             mem_valid;
  logic             mem_LS;
  logic [31:0]      mem_address;
  logic [31:0]      mem_store_value;
  logic             mem_BMS;
  logic             mem_valid_out;
  logic [31:0]      mem_load_value_out;
  logic             load_resp_valid;
  logic [31:0]      load_resp_value;
  logic [5:0]       load_resp_tag;
  logic [5:0]       load_resp_ROB_index;
  logic [CNT_W-1:0] store_fifo_count;
  logic             busy;

  modport slave (
    input  load_req_valid, load_req_addr, load_req_BMS, load_req_tag, load_req_ROB_index,
    input  store_req_valid, store_req_addr, store_req_value, store_req_BMS,
    input  mem_valid_out, mem_load_value_out,
    output load_req_ready, store_req_ready,
    output mem_valid, mem_LS, mem_address, mem_store_value, mem_BMS,
    output load_resp_valid, load_resp_value, load_resp_tag, load_resp_ROB_index,
    output store_fifo_count, busy
  );

  modport master (
    output load_req_valid, load_req_addr, load_req_BMS, load_req_tag, load_req_ROB_index,
    output store_req_valid, store_req_addr, store_req_value, store_req_BMS,
    output mem_valid_out, mem_load_value_out,
    input  load_req_ready, store_req_ready,
    input  mem_valid, mem_LS, mem_address, mem_store_value, mem_BMS,
    input  load_resp_valid, load_resp_value, load_resp_tag, load_resp_ROB_index,
    input  store_fifo_count, busy
  );
endinterface

// File: rtl/lsq_mem_controller.sv
// Arbitrates the single memory port between LSQ load misses and a retired-store drain FIFO,
// keeping one transaction outstanding and returning load data with its rd tag / ROB index.
module lsq_mem_controller #(
  parameter int STORE_FIFO_DEPTH = 4,
  parameter int STARVE_LIMIT     = 4
) (
  input logic                  clk,
  input logic                  reset,
  lsq_mem_controller_if.slave  bus
);
  localparam int PTR_W = $clog2(STORE_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(STORE_FIFO_DEPTH);
  localparam logic [SC_W-1:0]  STARVE_MAX = SC_W'(STARVE_LIMIT);

  typedef enum logic [2:0] {IDLE, ISSUE_LD, ISSUE_ST, WAIT_LD, WAIT_ST} state_e;
  state_e state_q, state_d;

  logic [31:0]      st_addr_q [STORE_FIFO_DEPTH];
  logic [31:0]      st_val_q  [STORE_FIFO_DEPTH];
  logic             st_bms_q  [STORE_FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, hz_idx;
  logic [CNT_W-1:0] count_q, count_d;
  logic [SC_W-1:0]  starve_q, starve_d;

  logic        mem_ls_q, mem_bms_q;
  logic [31:0] mem_addr_q, mem_val_q;
  logic [5:0]  ld_tag_q, ld_rob_q;
  logic        resp_valid_q;
  logic [31:0] resp_value_q;
  logic [5:0]  resp_tag_q, resp_rob_q;

  logic fifo_full, fifo_empty, enq, hazard, grant_ld, grant_st, resp_fire;

  function automatic logic [31:0] load_extend(input logic [31:0] raw, input logic byte_sel);
    return byte_sel ? {{24{raw[7]}}, raw[7:0]} : raw;
  endfunction

  assign fifo_full  = (count_q == FULL_CNT);
  assign fifo_empty = (count_q == '0);
  assign enq        = bus.store_req_valid && !fifo_full;
  assign resp_fire  = (state_q == WAIT_LD) && bus.mem_valid_out;

  // Word-granular match against every live FIFO entry plus a store entering this cycle.
  always_comb begin
    hazard = enq && (bus.store_req_addr[31:2] == bus.load_req_addr[31:2]);
    hz_idx = rd_ptr_q;
    for (int i = 0; i < STORE_FIFO_DEPTH; i++) begin
      hz_idx = rd_ptr_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (st_addr_q[hz_idx][31:2] == bus.load_req_addr[31:2]))
        hazard = 1'b1;
    end
  end

  always_comb begin
    grant_ld = 1'b0;
    grant_st = 1'b0;
    if (state_q == IDLE) begin
      if (fifo_full)                                   grant_st = 1'b1;
      else if ((starve_q == STARVE_MAX) && !fifo_empty) grant_st = 1'b1;
      else if (bus.load_req_valid && hazard)            grant_st = !fifo_empty;
      else if (bus.load_req_valid)                      grant_ld = 1'b1;
      else if (!fifo_empty)                             grant_st = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (grant_ld) state_d = ISSUE_LD; else if (grant_st) state_d = ISSUE_ST;
      ISSUE_LD: state_d = WAIT_LD;
      ISSUE_ST: state_d = WAIT_ST;
      WAIT_LD,
      WAIT_ST:  if (bus.mem_valid_out) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_valid       = (state_q == ISSUE_LD) || (state_q == ISSUE_ST);
    bus.busy            = (state_q != IDLE);
    bus.load_req_ready  = grant_ld;
    bus.store_req_ready = !fifo_full;
  end

  // Starvation counter only advances while a store is actually waiting behind loads.
  always_comb begin
    count_d  = count_q + CNT_W'(enq) - CNT_W'(grant_st);
    starve_d = starve_q;
    if (grant_st || fifo_empty)                starve_d = '0;
    else if (grant_ld && starve_q != STARVE_MAX) starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      if (enq)      wr_ptr_q <= wr_ptr_q + 1'b1;
      if (grant_st) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      st_addr_q[wr_ptr_q] <= bus.store_req_addr;
      st_val_q[wr_ptr_q]  <= bus.store_req_value;
      st_bms_q[wr_ptr_q]  <= bus.store_req_BMS;
    end
  end

  // Request fields are captured at grant and held until the next grant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_ls_q     <= 1'b0;
      mem_bms_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_val_q    <= '0;
      ld_tag_q     <= '0;
      ld_rob_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_value_q <= '0;
      resp_tag_q   <= '0;
      resp_rob_q   <= '0;
    end else begin
      if (grant_ld) begin
        mem_ls_q   <= 1'b1;
        mem_addr_q <= bus.load_req_addr;
        mem_bms_q  <= bus.load_req_BMS;
        ld_tag_q   <= bus.load_req_tag;
        ld_rob_q   <= bus.load_req_ROB_index;
      end else if (grant_st) begin
        mem_ls_q   <= 1'b0;
        mem_addr_q <= st_addr_q[rd_ptr_q];
        mem_val_q  <= st_val_q[rd_ptr_q];
        mem_bms_q  <= st_bms_q[rd_ptr_q];
      end
      resp_valid_q <= resp_fire;
      if (resp_fire) begin
        resp_value_q <= load_extend(bus.mem_load_value_out, mem_bms_q);
        resp_tag_q   <= ld_tag_q;
        resp_rob_q   <= ld_rob_q;
      end
    end
  end

  assign bus.mem_LS              = mem_ls_q;
  assign bus.mem_address         = mem_addr_q;
  assign bus.mem_store_value     = mem_val_q;
  assign bus.mem_BMS             = mem_bms_q;
  assign bus.load_resp_valid     = resp_valid_q;
  assign bus.load_resp_value     = resp_value_q;
  assign bus.load_resp_tag       = resp_tag_q;
  assign bus.load_resp_ROB_index = resp_rob_q;
  assign bus.store_fifo_count    = count_q;
endmodule
